// File: rtl/tlb_unit_pkg.sv
// rtl/tlb_unit_pkg.sv - shared TLB widths, CP0 register numbers and entry layout
package tlb_unit_pkg;

  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;
  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;

  // CP0 register numbers used by the surrounding decode
  localparam logic [4:0] INDEX    = 5'd0;
  localparam logic [4:0] ENTRYLO0 = 5'd2;
  localparam logic [4:0] ENTRYLO1 = 5'd3;
  localparam logic [4:0] ENTRYHI  = 5'd10;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [PFN_W-1:0]  pfn0;
    logic [2:0]        c0;
    logic              d0;
    logic              v0;
    logic [PFN_W-1:0]  pfn1;
    logic [2:0]        c1;
    logic              d1;
    logic              v1;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_match_port.sv
// rtl/tlb_match_port.sv - one associative search port: match, priority pick, page select
module tlb_match_port import tlb_unit_pkg::*; #(
  parameter int TLBNUM = tlb_unit_pkg::TLBNUM,
  parameter int IDXW   = tlb_unit_pkg::IDXW
) (
  input  tlb_entry_t [TLBNUM-1:0] entries_i,
  input  logic [VPN2_W-1:0]       vpn2_i,
  input  logic                    odd_page_i,
  input  logic [ASID_W-1:0]       asid_i,
  output logic                    found_o,
  output logic [IDXW-1:0]         index_o,
  output logic [PFN_W-1:0]        pfn_o,
  output logic [2:0]              c_o,
  output logic                    d_o,
  output logic                    v_o
);

  logic [TLBNUM-1:0] match;
  logic [IDXW-1:0]   hit_idx;
  tlb_entry_t        hit;

  // per-entry match: VPN2 equal and either global or same ASID
  always_comb begin
    match = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      match[i] = (entries_i[i].vpn2 == vpn2_i) &&
                 (entries_i[i].g || (entries_i[i].asid == asid_i));
    end
  end

  // priority encoder: scanning downward leaves the lowest hit, so multi-hit is deterministic
  always_comb begin
    hit_idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = IDXW'(i);
    end
  end

  assign found_o = |match;
  assign hit     = entries_i[hit_idx];

  // odd/even page select; everything reads zero on a miss
  always_comb begin
    index_o = '0;
    pfn_o   = '0;
    c_o     = '0;
    d_o     = 1'b0;
    v_o     = 1'b0;
    if (found_o) begin
      index_o = hit_idx;
      if (odd_page_i) begin
        pfn_o = hit.pfn1;
        c_o   = hit.c1;
        d_o   = hit.d1;
        v_o   = hit.v1;
      end else begin
        pfn_o = hit.pfn0;
        c_o   = hit.c0;
        d_o   = hit.d0;
        v_o   = hit.v0;
      end
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// rtl/tlb_unit.sv - fully associative joint TLB with fetch/data ports, TLBR/TLBW and probe
module tlb_unit import tlb_unit_pkg::*; #(
  parameter int TLBNUM = tlb_unit_pkg::TLBNUM,
  parameter int IDXW   = tlb_unit_pkg::IDXW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [VPN2_W-1:0] s0_vpn2,
  input  logic              s0_odd_page,
  input  logic [ASID_W-1:0] s0_asid,
  output logic              s0_found,
  output logic [IDXW-1:0]   s0_index,
  output logic [PFN_W-1:0]  s0_pfn,
  output logic [2:0]        s0_c,
  output logic              s0_d,
  output logic              s0_v,
  input  logic [VPN2_W-1:0] s1_vpn2,
  input  logic              s1_odd_page,
  input  logic [ASID_W-1:0] s1_asid,
  output logic              s1_found,
  output logic [IDXW-1:0]   s1_index,
  output logic [PFN_W-1:0]  s1_pfn,
  output logic [2:0]        s1_c,
  output logic              s1_d,
  output logic              s1_v,
  input  logic              tlbp_req,
  output logic              tlbp_found,
  output logic [IDXW-1:0]   tlbp_index,
  input  logic              we,
  input  logic              w_random,
  input  logic [IDXW-1:0]   w_index,
  input  logic [VPN2_W-1:0] w_vpn2,
  input  logic [ASID_W-1:0] w_asid,
  input  logic              w_g,
  input  logic [PFN_W-1:0]  w_pfn0,
  input  logic [2:0]        w_c0,
  input  logic              w_d0,
  input  logic              w_v0,
  input  logic [PFN_W-1:0]  w_pfn1,
  input  logic [2:0]        w_c1,
  input  logic              w_d1,
  input  logic              w_v1,
  input  logic [IDXW-1:0]   r_index,
  output logic [VPN2_W-1:0] r_vpn2,
  output logic [ASID_W-1:0] r_asid,
  output logic              r_g,
  output logic [PFN_W-1:0]  r_pfn0,
  output logic [2:0]        r_c0,
  output logic              r_d0,
  output logic              r_v0,
  output logic [PFN_W-1:0]  r_pfn1,
  output logic [2:0]        r_c1,
  output logic              r_d1,
  output logic              r_v1,
  output logic [IDXW-1:0]   random
);

  tlb_entry_t [TLBNUM-1:0] tlb_q, tlb_d;
  logic [IDXW-1:0]         random_q, random_d;
  logic                    tlbp_found_q, tlbp_found_d;
  logic [IDXW-1:0]         tlbp_index_q, tlbp_index_d;
  logic [IDXW-1:0]         w_sel;
  tlb_entry_t              w_entry;
  tlb_entry_t              r_entry;

  assign w_sel   = w_random ? random_q : w_index;
  assign w_entry = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                     pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                     pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};

  // next-state: write replaces a whole entry; Random free-runs down and wraps (Wired is 0);
  // probe index only moves on a probe hit
  always_comb begin
    tlb_d = tlb_q;
    if (we) tlb_d[w_sel] = w_entry;
    random_d     = random_q - IDXW'(1);
    tlbp_found_d = tlbp_req ? s1_found : tlbp_found_q;
    tlbp_index_d = (tlbp_req && s1_found) ? s1_index : tlbp_index_q;
  end

  // state registers; reset wins over a same-cycle write
  always_ff @(posedge clk) begin
    if (reset) begin
      tlb_q        <= '0;
      random_q     <= IDXW'(TLBNUM - 1);
      tlbp_found_q <= 1'b0;
      tlbp_index_q <= '0;
    end else begin
      tlb_q        <= tlb_d;
      random_q     <= random_d;
      tlbp_found_q <= tlbp_found_d;
      tlbp_index_q <= tlbp_index_d;
    end
  end

  assign random     = random_q;
  assign tlbp_found = tlbp_found_q;
  assign tlbp_index = tlbp_index_q;

  assign r_entry = tlb_q[r_index];
  assign r_vpn2  = r_entry.vpn2;
  assign r_asid  = r_entry.asid;
  assign r_g     = r_entry.g;
  assign r_pfn0  = r_entry.pfn0;
  assign r_c0    = r_entry.c0;
  assign r_d0    = r_entry.d0;
  assign r_v0    = r_entry.v0;
  assign r_pfn1  = r_entry.pfn1;
  assign r_c1    = r_entry.c1;
  assign r_d1    = r_entry.d1;
  assign r_v1    = r_entry.v1;

  tlb_match_port #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_s0 (
    .entries_i  (tlb_q),
    .vpn2_i     (s0_vpn2),
    .odd_page_i (s0_odd_page),
    .asid_i     (s0_asid),
    .found_o    (s0_found),
    .index_o    (s0_index),
    .pfn_o      (s0_pfn),
    .c_o        (s0_c),
    .d_o        (s0_d),
    .v_o        (s0_v)
  );

  tlb_match_port #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_s1 (
    .entries_i  (tlb_q),
    .vpn2_i     (s1_vpn2),
    .odd_page_i (s1_odd_page),
    .asid_i     (s1_asid),
    .found_o    (s1_found),
    .index_o    (s1_index),
    .pfn_o      (s1_pfn),
    .c_o        (s1_c),
    .d_o        (s1_d),
    .v_o        (s1_v)
  );

endmodule

// File: tb/tb_tlb_unit.sv
// tb/tb_tlb_unit.sv - scoreboard bench for tlb_unit
module tb_tlb_unit;
  import tlb_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] s0_vpn2, s1_vpn2, w_vpn2, r_vpn2;
  logic        s0_odd_page, s1_odd_page;
  logic [7:0]  s0_asid, s1_asid, w_asid, r_asid;
  logic        s0_found, s1_found, s0_d, s1_d, s0_v, s1_v;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic        tlbp_req, tlbp_found;
  logic [3:0]  tlbp_index;
  logic        we, w_random, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [3:0]  w_index, r_index, random;
  logic [19:0] w_pfn0, w_pfn1, r_pfn0, r_pfn1;
  logic [2:0]  w_c0, w_c1, r_c0, r_c1;
  logic        r_g, r_d0, r_v0, r_d1, r_v1;

  tlb_unit dut (
    .clk(clk), .reset(reset),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .tlbp_req(tlbp_req), .tlbp_found(tlbp_found), .tlbp_index(tlbp_index),
    .we(we), .w_random(w_random), .w_index(w_index),
    .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index),
    .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .random(random)
  );

  always #5 clk = ~clk;

  // reference Random counter
  logic [3:0] model_rand;
  always @(posedge clk) begin
    if (reset) model_rand <= 4'd15;
    else       model_rand <= model_rand - 4'd1;
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] asid,
                                    input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                                    input logic d0, input logic v0, input logic [19:0] pfn1,
                                    input logic [2:0] c1, input logic d1, input logic v1);
    tlb_entry_t e;
    e = '{vpn2: vpn2, asid: asid, g: g, pfn0: pfn0, c0: c0, d0: d0, v0: v0,
          pfn1: pfn1, c1: c1, d1: d1, v1: v1};
    return e;
  endfunction

  task automatic drive_w(input logic [3:0] idx, input tlb_entry_t e, input logic rnd);
    we = 1'b1; w_random = rnd; w_index = idx;
    w_vpn2 = e.vpn2; w_asid = e.asid; w_g = e.g;
    w_pfn0 = e.pfn0; w_c0 = e.c0; w_d0 = e.d0; w_v0 = e.v0;
    w_pfn1 = e.pfn1; w_c1 = e.c1; w_d1 = e.d1; w_v1 = e.v1;
  endtask

  task automatic wr(input logic [3:0] idx, input tlb_entry_t e);
    drive_w(idx, e, 1'b0);
    step();
    we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit hit4;
    reset = 1'b1; we = 1'b0; tlbp_req = 1'b0;
    drive_w(4'd0, '0, 1'b0); we = 1'b0;
    s0_vpn2 = 19'h1; s0_odd_page = 1'b0; s0_asid = 8'h0;
    s1_vpn2 = 19'h1; s1_odd_page = 1'b0; s1_asid = 8'h0;
    r_index = 4'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    push_exp("rst_random", 15); push_exp("rst_tlbp_found", 0);
    push_exp("rst_tlbp_index", 0); push_exp("rst_r_vpn2", 0);
    push_exp("rst_s0_found", 0);
    @(negedge clk);
    pop_cmp(random); pop_cmp(tlbp_found); pop_cmp(tlbp_index);
    pop_cmp(r_vpn2); pop_cmp(s0_found);
    step();

    // Random counts down and wraps
    for (int k = 1; k <= 16; k++) begin
      push_exp($sformatf("random_%0d", k), (15 - k) & 15);
      @(negedge clk);
      pop_cmp(random);
      step();
    end

    // TLBWI entry 3, odd/even select and ASID miss
    wr(4'd3, mk(19'h12, 8'h05, 1'b0, 20'h00100, 3'd3, 1'b0, 1'b1, 20'h00200, 3'd2, 1'b1, 1'b1));
    s0_vpn2 = 19'h12; s0_odd_page = 1'b1; s0_asid = 8'h05;
    push_exp("e3_found", 1); push_exp("e3_index", 3); push_exp("e3_pfn", 20'h200);
    push_exp("e3_c", 2); push_exp("e3_d", 1); push_exp("e3_v", 1);
    @(negedge clk);
    pop_cmp(s0_found); pop_cmp(s0_index); pop_cmp(s0_pfn);
    pop_cmp(s0_c); pop_cmp(s0_d); pop_cmp(s0_v);
    s0_odd_page = 1'b0;
    push_exp("e3_even_pfn", 20'h100); push_exp("e3_even_c", 3); push_exp("e3_even_d", 0);
    #1;
    pop_cmp(s0_pfn); pop_cmp(s0_c); pop_cmp(s0_d);
    s0_odd_page = 1'b1; s0_asid = 8'h06;
    push_exp("asid_miss_found", 0); push_exp("asid_miss_pfn", 0);
    push_exp("asid_miss_index", 0); push_exp("asid_miss_v", 0);
    #1;
    pop_cmp(s0_found); pop_cmp(s0_pfn); pop_cmp(s0_index); pop_cmp(s0_v);
    step();

    // global entry hits any ASID
    wr(4'd3, mk(19'h12, 8'h05, 1'b1, 20'h00100, 3'd3, 1'b0, 1'b1, 20'h00200, 3'd2, 1'b1, 1'b1));
    s0_asid = 8'hAA;
    push_exp("g_found", 1); push_exp("g_index", 3);
    @(negedge clk);
    pop_cmp(s0_found); pop_cmp(s0_index);
    step();

    // multiple hit: lowest index wins
    wr(4'd5, mk(19'h345, 8'h07, 1'b0, 20'h00555, 3'd0, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
    wr(4'd2, mk(19'h345, 8'h07, 1'b0, 20'h00222, 3'd0, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
    s1_vpn2 = 19'h345; s1_asid = 8'h07; s1_odd_page = 1'b0;
    push_exp("multi_found", 1); push_exp("multi_index", 2); push_exp("multi_pfn", 20'h222);
    @(negedge clk);
    pop_cmp(s1_found); pop_cmp(s1_index); pop_cmp(s1_pfn);
    step();

    // write vs same-cycle search/read sees old contents
    drive_w(4'd7, mk(19'h777, 8'h01, 1'b0, 20'h07777, 3'd0, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0), 1'b0);
    s0_vpn2 = 19'h777; s0_asid = 8'h01; s0_odd_page = 1'b0; r_index = 4'd7;
    push_exp("wcyc_found", 0); push_exp("wcyc_r_vpn2", 0); push_exp("wcyc_r_pfn0", 0);
    @(negedge clk);
    pop_cmp(s0_found); pop_cmp(r_vpn2); pop_cmp(r_pfn0);
    step();
    we = 1'b0;
    push_exp("wnext_found", 1); push_exp("wnext_index", 7);
    push_exp("wnext_pfn", 20'h7777); push_exp("wnext_r_vpn2", 19'h777);
    @(negedge clk);
    pop_cmp(s0_found); pop_cmp(s0_index); pop_cmp(s0_pfn); pop_cmp(r_vpn2);
    step();

    // probe hit, probe miss holds index, idle holds all
    wr(4'd9, mk(19'h999, 8'h02, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'h09999, 3'd0, 1'b0, 1'b1));
    s1_vpn2 = 19'h999; s1_asid = 8'h02; tlbp_req = 1'b1;
    push_exp("probe_pre_found", 0);
    @(negedge clk);
    pop_cmp(tlbp_found);
    step();
    tlbp_req = 1'b0;
    push_exp("probe_hit_found", 1); push_exp("probe_hit_index", 9);
    @(negedge clk);
    pop_cmp(tlbp_found); pop_cmp(tlbp_index);
    step();
    s1_vpn2 = 19'h1; tlbp_req = 1'b1;
    step();
    tlbp_req = 1'b0; s1_vpn2 = 19'h999;
    push_exp("probe_miss_found", 0); push_exp("probe_miss_index", 9);
    @(negedge clk);
    pop_cmp(tlbp_found); pop_cmp(tlbp_index);
    step();
    push_exp("probe_idle_found", 0); push_exp("probe_idle_index", 9);
    @(negedge clk);
    pop_cmp(tlbp_found); pop_cmp(tlbp_index);
    step();

    // TLBWR lands on the Random value of the write cycle
    hit4 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (model_rand == 4'd4) begin
        hit4 = 1'b1;
        break;
      end
      step();
    end
    check("rand_wait", 32'(hit4), 32'd1);
    drive_w(4'd0, mk(19'h444, 8'h03, 1'b0, 20'h04444, 3'd0, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0), 1'b1);
    push_exp("tlbwr_random", 4);
    @(negedge clk);
    pop_cmp(random);
    step();
    we = 1'b0;
    r_index = 4'd4;
    push_exp("tlbwr_r4_vpn2", 19'h444); push_exp("tlbwr_r4_pfn0", 20'h4444);
    #1; pop_cmp(r_vpn2); pop_cmp(r_pfn0);
    r_index = 4'd3;
    push_exp("tlbwr_r3_vpn2", 19'h12); push_exp("tlbwr_r3_g", 1);
    #1; pop_cmp(r_vpn2); pop_cmp(r_g);
    r_index = 4'd5;
    push_exp("tlbwr_r5_vpn2", 19'h345); push_exp("tlbwr_r5_pfn0", 20'h555);
    #1; pop_cmp(r_vpn2); pop_cmp(r_pfn0);
    r_index = 4'd0;
    push_exp("tlbwr_r0_vpn2", 0);
    #1; pop_cmp(r_vpn2);
    step();

    // reset mid-operation drops the write and clears probe state
    s1_vpn2 = 19'h999; s1_asid = 8'h02; tlbp_req = 1'b1;
    step();
    reset = 1'b1;
    drive_w(4'd11, mk(19'hBBB, 8'h0B, 1'b1, 20'h0BBBB, 3'd1, 1'b1, 1'b1, 20'h0BBBB, 3'd1, 1'b1, 1'b1), 1'b0);
    step();
    reset = 1'b0; we = 1'b0; tlbp_req = 1'b0; r_index = 4'd11;
    push_exp("rst2_r_vpn2", 0); push_exp("rst2_r_pfn0", 0); push_exp("rst2_random", 15);
    push_exp("rst2_tlbp_found", 0); push_exp("rst2_tlbp_index", 0); push_exp("rst2_s1_found", 0);
    @(negedge clk);
    pop_cmp(r_vpn2); pop_cmp(r_pfn0); pop_cmp(random);
    pop_cmp(tlbp_found); pop_cmp(tlbp_index); pop_cmp(s1_found);

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
